// File: rtl/laser_pkg.sv
// laser_pkg: constants and state encodings shared by the LASER front-end
// and the benches that drive LASER.
package laser_pkg;

    localparam int NUM_OBJ = 40;
    localparam int COORD_W = 4;
    localparam int PAIR_W  = 2 * COORD_W;
    localparam int IDX_W   = 6;
    localparam int WDOG_W  = 18;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_PRIME  = 3'd1;
    localparam logic [2:0] ST_STREAM = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_HOLD   = 3'd4;

    // Objects are stored as {y, x} so the low half is always the x coordinate.
    function automatic logic [PAIR_W-1:0] pack_obj(input logic [COORD_W-1:0] x,
                                                   input logic [COORD_W-1:0] y);
        return {y, x};
    endfunction

endpackage

// File: rtl/laser_obj_bank.sv
// laser_obj_bank: ping-pong object store, two frames of NUM_OBJ packed
// coordinate pairs, one synchronous write port and one combinational read.
module laser_obj_bank import laser_pkg::*; (
    input  logic              CLK,
    input  logic              wr_en,
    input  logic              wr_bank,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [PAIR_W-1:0] wr_data,
    input  logic              rd_bank,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [PAIR_W-1:0] rd_data
);

    logic [PAIR_W-1:0] mem [2][NUM_OBJ];

    // Host writes land in whichever bank the input path is currently filling.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_bank][wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_bank][rd_idx];

endmodule

// File: rtl/laser_feeder.sv
// laser_feeder: buffers host objects into ping-pong frames, streams each
// frame into LASER, catches DONE (or aborts on the watchdog) and returns
// the two circle centres over a valid/ready result port.
module laser_feeder import laser_pkg::*; #(
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic [COORD_W-1:0] IN_X,
    input  logic [COORD_W-1:0] IN_Y,
    output logic               L_RST,
    output logic [COORD_W-1:0] L_X,
    output logic [COORD_W-1:0] L_Y,
    input  logic               L_DONE,
    input  logic [COORD_W-1:0] L_C1X,
    input  logic [COORD_W-1:0] L_C1Y,
    input  logic [COORD_W-1:0] L_C2X,
    input  logic [COORD_W-1:0] L_C2Y,
    output logic               RES_VALID,
    input  logic               RES_READY,
    output logic [COORD_W-1:0] RES_C1X,
    output logic [COORD_W-1:0] RES_C1Y,
    output logic [COORD_W-1:0] RES_C2X,
    output logic [COORD_W-1:0] RES_C2Y,
    output logic               RES_TIMEOUT
);

    logic              wr_bank;
    logic              rd_bank;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic [IDX_W-1:0]  rd_addr;
    logic [1:0]        full;
    logic [1:0]        full_next;
    logic [2:0]        state;
    logic [WDOG_W-1:0] wdog;
    logic [PAIR_W-1:0] rd_data;
    logic              in_fire;
    logic              frame_set;
    logic              frame_clr;
    logic              stream_last;
    logic              wdog_hit;
    logic              done_hit;

    assign IN_READY    = !full[wr_bank];
    assign in_fire     = IN_VALID & IN_READY;
    assign frame_set   = in_fire && (wr_idx == IDX_W'(NUM_OBJ - 1));
    assign stream_last = (state == ST_STREAM) && (rd_idx == IDX_W'(NUM_OBJ));
    assign frame_clr   = stream_last;
    assign wdog_hit    = (state == ST_WAIT) && (wdog == WDOG_W'(TIMEOUT_CYC - 1));
    assign done_hit    = (state == ST_WAIT) && L_DONE;

    // LASER is held in reset everywhere except while it is being fed or computing.
    assign L_RST = (state != ST_STREAM) && (state != ST_WAIT);

    // PRIME always fetches object 0; the final STREAM cycle has no object left to fetch.
    assign rd_addr = (state == ST_STREAM && rd_idx < IDX_W'(NUM_OBJ)) ? rd_idx : '0;

    laser_obj_bank u_bank (
        .CLK     (CLK),
        .wr_en   (in_fire),
        .wr_bank (wr_bank),
        .wr_idx  (wr_idx),
        .wr_data (pack_obj(IN_X, IN_Y)),
        .rd_bank (rd_bank),
        .rd_idx  (rd_addr),
        .rd_data (rd_data)
    );

    // Write pointer walks one bank, then flips to the other once a frame completes.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_bank <= 1'b0;
            wr_idx  <= '0;
        end else if (in_fire) begin
            if (wr_idx == IDX_W'(NUM_OBJ - 1)) begin
                wr_bank <= ~wr_bank;
                wr_idx  <= '0;
            end else begin
                wr_idx <= wr_idx + 1'b1;
            end
        end
    end

    // Filling one bank and draining the other can coincide; both updates apply.
    always_comb begin
        full_next = full;
        if (frame_set) full_next[wr_bank] = 1'b1;
        if (frame_clr) full_next[rd_bank] = 1'b0;
    end

    // Bank occupancy flags.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            full <= '0;
        end else begin
            full <= full_next;
        end
    end

    // Launch sequencer: prime object 0, stream the frame, then wait for DONE or the watchdog.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= ST_IDLE;
            rd_bank <= 1'b0;
            rd_idx  <= '0;
            wdog    <= '0;
            L_X     <= '0;
            L_Y     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (full[rd_bank] && !RES_VALID) state <= ST_PRIME;
                end
                ST_PRIME: begin
                    L_X    <= rd_data[COORD_W-1:0];
                    L_Y    <= rd_data[PAIR_W-1:COORD_W];
                    rd_idx <= IDX_W'(1);
                    state  <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (stream_last) begin
                        rd_bank <= ~rd_bank;
                        rd_idx  <= '0;
                        wdog    <= '0;
                        state   <= ST_WAIT;
                    end else begin
                        L_X    <= rd_data[COORD_W-1:0];
                        L_Y    <= rd_data[PAIR_W-1:COORD_W];
                        rd_idx <= rd_idx + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (done_hit || wdog_hit) begin
                        state <= ST_HOLD;
                    end else if (wdog != '1) begin
                        wdog <= wdog + 1'b1;
                    end
                end
                ST_HOLD: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Result slot: filled from WAIT, held stable until the host takes it.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            RES_VALID   <= 1'b0;
            RES_TIMEOUT <= 1'b0;
            RES_C1X     <= '0;
            RES_C1Y     <= '0;
            RES_C2X     <= '0;
            RES_C2Y     <= '0;
        end else if (done_hit) begin
            RES_VALID   <= 1'b1;
            RES_TIMEOUT <= 1'b0;
            RES_C1X     <= L_C1X;
            RES_C1Y     <= L_C1Y;
            RES_C2X     <= L_C2X;
            RES_C2Y     <= L_C2Y;
        end else if (wdog_hit) begin
            RES_VALID   <= 1'b1;
            RES_TIMEOUT <= 1'b1;
            RES_C1X     <= '0;
            RES_C1Y     <= '0;
            RES_C2X     <= '0;
            RES_C2Y     <= '0;
        end else if (RES_VALID && RES_READY) begin
            RES_VALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_laser_feeder.sv
// tb_laser_feeder: directed frames into laser_feeder with a behavioural LASER
// model; expected results go into a scoreboard queue checked by a monitor.
module tb_laser_feeder;

    localparam int TIMEOUT = 100;
    localparam int NOBJ    = 40;

    typedef struct {
        logic [3:0] c1x;
        logic [3:0] c1y;
        logic [3:0] c2x;
        logic [3:0] c2y;
        logic       to;
    } res_t;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       IN_VALID = 1'b0;
    logic       IN_READY;
    logic [3:0] IN_X = '0;
    logic [3:0] IN_Y = '0;
    logic       L_RST;
    logic [3:0] L_X;
    logic [3:0] L_Y;
    logic       L_DONE;
    logic [3:0] L_C1X = '0;
    logic [3:0] L_C1Y = '0;
    logic [3:0] L_C2X = '0;
    logic [3:0] L_C2Y = '0;
    logic       RES_VALID;
    logic       RES_READY = 1'b1;
    logic [3:0] RES_C1X;
    logic [3:0] RES_C1Y;
    logic [3:0] RES_C2X;
    logic [3:0] RES_C2Y;
    logic       RES_TIMEOUT;

    logic model_done = 1'b0;
    logic spur_done  = 1'b0;
    assign L_DONE = model_done | spur_done;

    int   tests_run = 0;
    int   tests_failed = 0;
    int   cyc = 0;
    int   stalls = 0;
    int   last_hs_cyc = 0;
    int   low_cnt = 0;
    int   done_cyc = 0;
    int   model_delay = 5;
    logic done_en = 1'b1;
    logic in_frame = 1'b0;
    logic prev_valid = 1'b0;

    logic [7:0] obj_q[$];
    res_t       res_q[$];
    res_t       model_q[$];
    int         start_log[$];
    int         done_log[$];

    laser_feeder #(.TIMEOUT_CYC(TIMEOUT)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .IN_VALID    (IN_VALID),
        .IN_READY    (IN_READY),
        .IN_X        (IN_X),
        .IN_Y        (IN_Y),
        .L_RST       (L_RST),
        .L_X         (L_X),
        .L_Y         (L_Y),
        .L_DONE      (L_DONE),
        .L_C1X       (L_C1X),
        .L_C1Y       (L_C1Y),
        .L_C2X       (L_C2X),
        .L_C2Y       (L_C2Y),
        .RES_VALID   (RES_VALID),
        .RES_READY   (RES_READY),
        .RES_C1X     (RES_C1X),
        .RES_C1Y     (RES_C1Y),
        .RES_C2X     (RES_C2X),
        .RES_C2Y     (RES_C2Y),
        .RES_TIMEOUT (RES_TIMEOUT)
    );

    // Free-running clock and cycle counter.
    initial forever #5 CLK = ~CLK;
    initial forever begin
        @(posedge CLK);
        cyc = cyc + 1;
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic fail_bound(input string name);
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL %s: bound expired at cycle %0d", name, cyc);
    endtask

    function automatic logic [7:0] obj_of(input int pat, input int i);
        int x;
        int y;
        case (pat)
            0:       begin x = i % 16;        y = i / 16 + 2;      end
            1:       begin x = (i * 3) % 16;  y = (i * 7 + 1) % 16; end
            2:       begin x = 15 - (i % 16); y = i % 8;           end
            default: begin x = (i + 5) % 16;  y = (i * 5) % 16;    end
        endcase
        return {4'(y), 4'(x)};
    endfunction

    task automatic push_result(input logic [3:0] c1x, input logic [3:0] c1y,
                               input logic [3:0] c2x, input logic [3:0] c2y,
                               input logic to);
        res_t r;
        r.c1x = c1x; r.c1y = c1y; r.c2x = c2x; r.c2y = c2y; r.to = to;
        res_q.push_back(r);
        if (!to) model_q.push_back(r);
    endtask

    // One object handshake; called in the phase just after a rising edge.
    task automatic apply_stimulus(input logic [3:0] x, input logic [3:0] y);
        bit ok = 1'b0;
        IN_VALID = 1'b1;
        IN_X = x;
        IN_Y = y;
        for (int n = 0; n < 3000 && !ok; n++) begin
            @(negedge CLK);
            if (IN_READY) ok = 1'b1;
            else stalls++;
        end
        if (!ok) begin
            fail_bound("in_handshake");
        end else begin
            last_hs_cyc = cyc;
            @(posedge CLK);
            #1;
        end
        IN_VALID = 1'b0;
    endtask

    task automatic send_frame(input int pat);
        logic [7:0] o;
        for (int i = 0; i < NOBJ; i++) begin
            o = obj_of(pat, i);
            obj_q.push_back(o);
            apply_stimulus(o[3:0], o[7:4]);
        end
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int n = 0; n < 4000 && !ok; n++) begin
            @(negedge CLK);
            #2;
            if (res_q.size() == 0 && !RES_VALID && L_RST && !in_frame) ok = 1'b1;
        end
        if (!ok) fail_bound(name);
        @(posedge CLK);
        #1;
    endtask

    // LASER model: checks the streamed objects and the low time of L_RST, answers with DONE.
    initial begin
        res_t r;
        logic [7:0] exp_obj;
        forever begin
            @(negedge CLK);
            model_done = 1'b0;
            if (!RST_N) begin
                in_frame = 1'b0;
                low_cnt  = 0;
            end else if (!L_RST) begin
                if (!in_frame) begin
                    in_frame = 1'b1;
                    low_cnt  = 0;
                    start_log.push_back(cyc);
                end
                low_cnt++;
                if (low_cnt <= NOBJ) begin
                    if (obj_q.size() == 0) begin
                        fail_bound("stream_extra");
                    end else begin
                        exp_obj = obj_q.pop_front();
                        check_output("stream_obj", 32'({L_Y, L_X}), 32'(exp_obj));
                    end
                end else if (done_en && low_cnt == NOBJ + model_delay) begin
                    if (model_q.size() == 0) begin
                        fail_bound("model_result");
                    end else begin
                        r = model_q.pop_front();
                        L_C1X = r.c1x; L_C1Y = r.c1y; L_C2X = r.c2x; L_C2Y = r.c2y;
                        model_done = 1'b1;
                        done_cyc = cyc;
                        done_log.push_back(cyc);
                    end
                end
            end else if (in_frame) begin
                in_frame = 1'b0;
                check_output("lrst_low_len", low_cnt,
                             done_en ? NOBJ + model_delay : NOBJ + TIMEOUT);
            end
        end
    end

    // Result monitor: pops the scoreboard on each result handshake.
    initial begin
        res_t e;
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                prev_valid = 1'b0;
            end else begin
                if (RES_VALID && !prev_valid) begin
                    if (res_q.size() == 0) fail_bound("unexpected_result");
                    else if (!res_q[0].to) check_output("done_to_valid", cyc, done_cyc + 1);
                end
                if (RES_VALID && RES_READY && res_q.size() > 0) begin
                    e = res_q.pop_front();
                    check_output("result",
                                 {15'd0, RES_C1X, RES_C1Y, RES_C2X, RES_C2Y, RES_TIMEOUT},
                                 {15'd0, e.c1x, e.c1y, e.c2x, e.c2y, e.to});
                end
                prev_valid = RES_VALID;
            end
        end
    end

    initial begin
        #3000000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] stopped");
    end

    // Directed scenario sequence.
    initial begin
        int s0;
        int d0;
        bit ok;

        repeat (3) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        check_output("rst_in_ready", 32'(IN_READY), 1);
        check_output("rst_l_rst", 32'(L_RST), 1);
        check_output("rst_l_xy", 32'({L_Y, L_X}), 0);
        check_output("rst_res_valid", 32'(RES_VALID), 0);
        check_output("rst_res_c", 32'({RES_C1X, RES_C1Y, RES_C2X, RES_C2Y}), 0);
        check_output("rst_res_timeout", 32'(RES_TIMEOUT), 0);

        $display("[TB] single frame");
        s0 = start_log.size();
        push_result(4'd3, 4'd4, 4'd12, 4'd9, 1'b0);
        send_frame(0);
        wait_idle("single_idle");
        check_output("single_starts", start_log.size(), s0 + 1);
        if (start_log.size() > s0) check_output("launch_latency", start_log[s0], last_hs_cyc + 3);
        else fail_bound("launch_log");

        $display("[TB] spurious done");
        @(negedge CLK); #2; spur_done = 1'b1;
        @(negedge CLK); #2; spur_done = 1'b0;
        repeat (5) @(negedge CLK);
        #2;
        check_output("spur_idle_valid", 32'(RES_VALID), 0);
        @(posedge CLK); #1;
        push_result(4'd5, 4'd6, 4'd10, 4'd11, 1'b0);
        send_frame(1);
        ok = 1'b0;
        for (int n = 0; n < 500 && !ok; n++) begin
            @(negedge CLK); #2;
            if (in_frame && low_cnt == 10) ok = 1'b1;
        end
        if (!ok) fail_bound("spur_stream_wait");
        spur_done = 1'b1;
        @(negedge CLK); #2;
        spur_done = 1'b0;
        wait_idle("spur_idle");

        $display("[TB] back-to-back");
        s0 = start_log.size();
        d0 = done_log.size();
        stalls = 0;
        push_result(4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
        push_result(4'd9, 4'd8, 4'd7, 4'd6, 1'b0);
        send_frame(2);
        send_frame(3);
        check_output("b2b_in_ready_stalls", stalls, 0);
        wait_idle("b2b_idle");
        if (start_log.size() > s0 + 1 && done_log.size() > d0)
            check_output("b2b_gap", start_log[s0 + 1], done_log[d0] + 4);
        else
            fail_bound("b2b_log");

        $display("[TB] result backpressure");
        RES_READY = 1'b0;
        s0 = start_log.size();
        push_result(4'd14, 4'd1, 4'd2, 4'd13, 1'b0);
        push_result(4'd6, 4'd7, 4'd8, 4'd9, 1'b0);
        send_frame(1);
        send_frame(0);
        ok = 1'b0;
        for (int n = 0; n < 1000 && !ok; n++) begin
            @(negedge CLK); #2;
            if (RES_VALID) ok = 1'b1;
        end
        if (!ok) fail_bound("bp_first_result");
        repeat (500) @(negedge CLK);
        #2;
        check_output("bp_no_launch", start_log.size(), s0 + 1);
        check_output("bp_valid_held", 32'(RES_VALID), 1);
        check_output("bp_held_c1x", 32'(RES_C1X), 14);
        @(posedge CLK); #1;
        RES_READY = 1'b1;
        wait_idle("bp_idle");
        check_output("bp_second_launch", start_log.size(), s0 + 2);

        $display("[TB] watchdog");
        done_en = 1'b0;
        push_result(4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
        send_frame(3);
        wait_idle("wdog_idle");
        done_en = 1'b1;
        check_output("wdog_l_rst", 32'(L_RST), 1);

        $display("[TB] reset mid-stream");
        send_frame(1);
        ok = 1'b0;
        for (int n = 0; n < 500 && !ok; n++) begin
            @(negedge CLK); #2;
            if (in_frame && low_cnt == 18) ok = 1'b1;
        end
        if (!ok) fail_bound("rst_stream_wait");
        RST_N = 1'b0;
        #1;
        check_output("mid_rst_l_rst", 32'(L_RST), 1);
        check_output("mid_rst_in_ready", 32'(IN_READY), 1);
        check_output("mid_rst_l_xy", 32'({L_Y, L_X}), 0);
        obj_q.delete();
        repeat (3) @(negedge CLK);
        @(posedge CLK); #1;
        RST_N = 1'b1;
        @(posedge CLK); #1;
        push_result(4'd15, 4'd0, 4'd7, 4'd8, 1'b0);
        send_frame(2);
        wait_idle("post_rst_idle");

        check_output("res_q_drained", res_q.size(), 0);
        check_output("obj_q_drained", obj_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/laser_feeder.md
# laser_feeder

Front-end stage for the LASER circle-placement core. It accepts object coordinates from a host over a valid/ready stream and buffers each 40-object frame in a ping-pong store. For every buffered frame it resets LASER, streams the 40 points on consecutive cycles, and catches the one-cycle DONE pulse. It then returns the two circle centres to the host over a valid/ready result port. A watchdog terminates frames that never finish.

## Interface
- NUM_OBJ, 40, objects per frame; LASER requires exactly 40.
- COORD_W, 4, coordinate width.
- TIMEOUT_CYC, 200000, maximum cycles to wait for L_DONE before aborting a frame.

- CLK  in  1  rising-edge clock, shared with LASER.
- RST_N  in  1  asynchronous, active-low reset.
- IN_VALID  in  1  host object valid.
- IN_READY  out  1  feeder can accept an object.
- IN_X, IN_Y  in  4 each  object coordinates.
- L_RST  out  1  active-high synchronous reset to LASER.
- L_X, L_Y  out  4 each  object stream to LASER.
- L_DONE  in  1  LASER completion pulse.
- L_C1X, L_C1Y, L_C2X, L_C2Y  in  4 each  LASER results.
- RES_VALID  out  1  result available.
- RES_READY  in  1  host consumes result.
- RES_C1X, RES_C1Y, RES_C2X, RES_C2Y  out  4 each  captured centres.
- RES_TIMEOUT  out  1  result produced by watchdog abort.

## Operation
- **Input path**
  - Two banks of NUM_OBJ×8 bits. Registers: wr_bank, wr_idx (6 b), full[1:0].
  - IN_READY = !full[wr_bank]. Handshake = IN_VALID & IN_READY; writes {IN_Y, IN_X} to bank[wr_bank][wr_idx] and increments wr_idx.
  - The handshake with wr_idx==39 sets full[wr_bank], toggles wr_bank and clears wr_idx.
- **Launch FSM**: IDLE, PRIME, STREAM, WAIT, HOLD.
  - IDLE: L_RST=1. Go to PRIME when full[rd_bank] & !RES_VALID.
  - PRIME (1 cycle): L_RST=1; loads L_X/L_Y with object 0 and sets rd_idx=1.
  - STREAM (40 cycles): L_RST=0. L_X/L_Y hold object k in the k-th cycle after L_RST falls. In the last cycle, clear full[rd_bank], toggle rd_bank, go to WAIT.
  - WAIT: L_RST=0; watchdog counter increments.
    - L_DONE=1 → capture L_C* into RES_C*, RES_TIMEOUT=0, RES_VALID=1, go to HOLD.
    - Counter reaching TIMEOUT_CYC-1 → RES_C*=0, RES_TIMEOUT=1, RES_VALID=1, go to HOLD.
  - HOLD (1 cycle): L_RST=1, which parks LASER (it re-enters its input state after DONE). Then go to IDLE.
- **Result port**: RES_VALID stays set until RES_VALID & RES_READY, then clears. RES_C* are stable while valid.
- **Simultaneous events**
  - Set of full on one bank and clear on the other in the same cycle: both take effect.
  - Set and clear never target the same bank.
  - RES_READY in the same cycle IDLE evaluates launch: launch waits one cycle, because the launch condition uses registered RES_VALID.
- L_DONE outside WAIT is ignored.
- Reset (any time, including mid-STREAM or mid-WAIT): state=IDLE, L_RST=1, full=0, wr/rd indices and banks=0, watchdog=0. The partial frame is discarded; LASER stays held in reset.

## Timing
- Reset values: IN_READY=1 after reset release (bank 0 empty), L_RST=1, L_X=L_Y=0, RES_VALID=0, RES_C*=0, RES_TIMEOUT=0.
- Write-to-launch: the 40th input handshake at edge E makes PRIME active in cycle E+2 and STREAM begin at E+3, provided the result slot is empty.
- L_RST is high for at least 1 cycle before every frame; object 0 is on L_X/L_Y in the first cycle L_RST is low.
- Host may fill the second bank fully during STREAM/WAIT of the first. IN_READY drops only when both banks are full.
- DONE-to-RES_VALID: 1 cycle (RES_VALID visible the cycle after L_DONE). Minimum frame-to-frame gap: HOLD + IDLE + PRIME = 3 cycles.
- Watchdog counter is 18 bits and saturates; it clears on entry to WAIT.

## Structure
- **laser_pkg**: NUM_OBJ, COORD_W, FSM state encodings (3 b), and the coordinate-pair width constant; shared with LASER-side benches.
- **laser_obj_bank**: a sub-module holding 2×40×8 storage with one synchronous write port and one combinational read port (bank, index). The FSM, index counters, watchdog and result register stay in laser_feeder.

## Test plan
- Single frame, objects (i%16, i/16+2) for i=0..39, RES_READY=1, LASER model returns C1=(3,4), C2=(12,9) → L_RST low exactly 40 cycles before WAIT, L_X/L_Y match sequence, RES_VALID one cycle after L_DONE with RES_C*=3,4,12,9, RES_TIMEOUT=0.
- Back-to-back: host pushes 80 objects continuously → IN_READY never drops before handshake 80; second PRIME starts 3 cycles after first L_DONE; two results in order.
- Result backpressure: RES_READY=0 for 500 cycles with a second frame buffered → no second launch until the first result is consumed; then launch with no lost frame.
- Watchdog: TIMEOUT_CYC=100, L_DONE never asserted → RES_VALID at WAIT cycle 100 with RES_C*=0, RES_TIMEOUT=1; L_RST returns high.
- Reset mid-STREAM at object 17 → L_RST=1 and IN_READY=1 immediately; a following clean frame streams from object 0 and produces the correct result.
- Spurious L_DONE during IDLE/STREAM → ignored, no RES_VALID.
